spi_master: RTL and testbench
=============================

# spi_master

SPI bus master that serialises one DATA_WIDTH-bit word per transfer on MOSI while simultaneously capturing a word from MISO. It supports all four SPI modes selected by MODE, and generates SClk and SS from the system clock Clk. It is the initiator counterpart of spi_slave: the two are wired directly MOSI-to-MOSI, MISO-to-MISO, SClk-to-SClk and SS-to-SS in the loopback test system.

## Interface
- DATA_WIDTH, 8: bits per transfer; must be ≥ 2.
- CLK_DIV, 4: SClk half-period in Clk cycles; must be ≥ 2. SClk frequency = Clk / (2*CLK_DIV).

- Clk  input  1  system clock; all logic is on the rising edge.
- Rst_n  input  1  synchronous, active-low reset.
- MODE  input  2  SPI mode. CPOL = MODE[1], CPHA = MODE[0]. Latched at Start.
- Start  input  1  transfer request; sampled only in IDLE.
- TxData  input  DATA_WIDTH  word to transmit, MSB first; latched at Start.
- Busy  output  1  high from the cycle after Start acceptance until Done.
- Done  output  1  one-cycle pulse at the end of a transfer.
- RxData  output  DATA_WIDTH  last received word; updated in the Done cycle.
- SClk  output  1  SPI clock.
- MOSI  output  1  serial data out.
- SS  output  1  slave select, active-low.
- MISO  input  1  serial data in; sampled directly with no synchroniser.

## Operation
- States: IDLE → SETUP → XFER → HOLD → IDLE.
- **IDLE**
  - SS = 1, MOSI = 0, Busy = 0.
  - SClk is registered from MODE[1] every cycle, so the idle level tracks the current mode.
  - Start = 1 latches MODE, TxData and the shift register, then moves to SETUP.
- **SETUP** (CLK_DIV cycles)
  - SS = 0, SClk = CPOL.
  - If CPHA = 0, MOSI = TxData[MSB] from the first SETUP cycle.
- **XFER**
  - SClk toggles every CLK_DIV cycles, for exactly 2*DATA_WIDTH edges.
  - The leading edge is the odd edge (the one leaving CPOL); the trailing edge is the even edge.
  - CPHA = 0: sample MISO on leading edges; shift MOSI to the next bit on trailing edges. The final trailing edge shifts nothing.
  - CPHA = 1: drive MOSI with the next bit on leading edges, starting with the MSB on edge 1; sample MISO on trailing edges.
  - "Sample" means: at the Clk edge that drives the SClk transition, shift MISO into the LSB of the rx shift register.
- **HOLD** (CLK_DIV cycles): SClk = CPOL, SS stays low, MOSI holds its value.
- **Exit to IDLE**
  - SS = 1, MOSI = 0.
  - RxData is loaded from the rx shift register.
  - Done = 1 for one cycle and Busy falls, all in the same cycle.
- Edge counter width: clog2(2*DATA_WIDTH+1). Divider counter width: clog2(CLK_DIV).
- Start while Busy is ignored. MODE/TxData changes while Busy are ignored.
- Start held high continuously gives back-to-back transfers: the next one is accepted in the Done cycle, so SS is high for exactly 1 cycle between transfers.

## Timing
- Reset values: SS = 1, SClk = 0, MOSI = 0, Busy = 0, Done = 0, RxData = 0. All counters are zero and the state is IDLE.
- Let Start be sampled at Clk edge t0. Then:
  - SS falls at t0+1.
  - SClk edge k (k = 1..2*DATA_WIDTH) occurs at t0+1+k*CLK_DIV.
  - SS rises and Done pulses at t0+1+(2*DATA_WIDTH+1)*CLK_DIV.
- Defaults (DATA_WIDTH = 8, CLK_DIV = 4): first SClk edge at t0+5, last at t0+65, Done at t0+69.
- Each MOSI bit is stable for at least 2*CLK_DIV-1 Clk cycles around its sample edge.
- Reset mid-transfer: on the next Clk edge all outputs return to reset values, SS rises immediately and no Done is produced. RxData is cleared to 0.
- Start in the same cycle as Rst_n = 0: reset wins and the Start is dropped.

## Test plan
- MODE = 00, TxData = 0xA5, responder slave loaded with 0x3C, Start at t0 → MOSI bits at leading edges 1,0,1,0,0,1,0,1; RxData = 0x3C; Done at t0+69; SS low for exactly t0+1..t0+68.
- All four modes, TxData = 0x81 against slave TxData = 0x7E → RxData = 0x7E and the slave's RxData = 0x81 in every mode. SClk idles at MODE[1] before and after each transfer.
- Start held high for 3 transfers (0x01, 0x02, 0x03) → three Done pulses 69 cycles apart; SS high for 1 cycle between transfers; slave receives 0x01, 0x02, 0x03.
- Start pulsed at t0+10 and t0+40 during a transfer → ignored; exactly one Done at t0+69; Busy stays 1 throughout.
- Rst_n low at t0+30 for 1 cycle → SS = 1, SClk = 0, Busy = 0, RxData = 0 at t0+31; no Done; a fresh Start at t0+40 completes normally with Done at t0+109.
- CLK_DIV = 2, DATA_WIDTH = 16, TxData = 0xBEEF, MODE = 11 → Done at t0+1+33*2 = t0+67; RxData equals the slave's word.

Source files
------------

// File: rtl/spi_master.sv
// SPI master: shifts one DATA_WIDTH word out on MOSI while capturing one from MISO.
// SClk, SS and MOSI are registered; MISO is sampled on the Clk edge that moves SClk.
module spi_master #(
  parameter int DATA_WIDTH = 8,
  parameter int CLK_DIV    = 4
) (
  input  logic                  Clk,
  input  logic                  Rst_n,
  input  logic [1:0]            MODE,
  input  logic                  Start,
  input  logic [DATA_WIDTH-1:0] TxData,
  output logic                  Busy,
  output logic                  Done,
  output logic [DATA_WIDTH-1:0] RxData,
  output logic                  SClk,
  output logic                  MOSI,
  output logic                  SS,
  input  logic                  MISO
);

  // state | meaning
  // IDLE  | SS high, SClk follows MODE[1], waiting for Start
  // SETUP | SS low, SClk at CPOL for CLK_DIV cycles before the first edge
  // XFER  | SClk toggles every CLK_DIV cycles, 2*DATA_WIDTH edges
  // HOLD  | SClk back at CPOL for CLK_DIV cycles, then Done
  typedef enum logic [1:0] {IDLE, SETUP, XFER, HOLD} state_e;

  localparam int EW   = $clog2(2*DATA_WIDTH+1);
  localparam int DIVW = $clog2(CLK_DIV);
  localparam logic [DIVW-1:0] DIV_LOAD  = DIVW'(CLK_DIV-1);
  localparam logic [EW-1:0]   EDGE_LOAD = EW'(2*DATA_WIDTH);

  state_e                  state_q, state_d;
  logic [1:0]              mode_q, mode_d;
  logic [DIVW-1:0]         div_q, div_d;
  logic [EW-1:0]           edge_q, edge_d;
  logic [DATA_WIDTH-1:0]   tx_sh_q, tx_sh_d;
  logic [DATA_WIDTH-1:0]   rx_sh_q, rx_sh_d;
  logic [DATA_WIDTH-1:0]   rx_data_q, rx_data_d;
  logic                    sclk_q, sclk_d;
  logic                    mosi_q, mosi_d;
  logic                    ss_q, ss_d;
  logic                    done_q, done_d;
  logic                    leading;

  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    div_d     = div_q;
    edge_d    = edge_q;
    tx_sh_d   = tx_sh_q;
    rx_sh_d   = rx_sh_q;
    rx_data_d = rx_data_q;
    sclk_d    = sclk_q;
    mosi_d    = mosi_q;
    ss_d      = ss_q;
    done_d    = 1'b0;
    // edge_q counts edges still to go; with an even total, an even remainder is a leading edge
    leading   = ~edge_q[0];

    unique case (state_q)
      IDLE: begin
        sclk_d = MODE[1];
        ss_d   = 1'b1;
        mosi_d = 1'b0;
        if (Start) begin
          state_d = SETUP;
          mode_d  = MODE;
          tx_sh_d = TxData;
          rx_sh_d = '0;
          div_d   = DIV_LOAD;
          edge_d  = EDGE_LOAD;
          ss_d    = 1'b0;
          mosi_d  = MODE[0] ? 1'b0 : TxData[DATA_WIDTH-1];
        end
      end
      SETUP, XFER: begin
        if (div_q == '0) begin
          div_d   = DIV_LOAD;
          edge_d  = edge_q - EW'(1);
          sclk_d  = ~sclk_q;
          state_d = (edge_q == EW'(1)) ? HOLD : XFER;
          if (leading != mode_q[0]) begin
            rx_sh_d = {rx_sh_q[DATA_WIDTH-2:0], MISO};
          end else if (mode_q[0]) begin
            mosi_d  = tx_sh_q[DATA_WIDTH-1];
            tx_sh_d = tx_sh_q << 1;
          end else if (edge_q != EW'(1)) begin
            mosi_d  = tx_sh_q[DATA_WIDTH-2];
            tx_sh_d = tx_sh_q << 1;
          end
        end else begin
          div_d = div_q - DIVW'(1);
        end
      end
      HOLD: begin
        sclk_d = mode_q[1];
        if (div_q == '0) begin
          state_d   = IDLE;
          done_d    = 1'b1;
          ss_d      = 1'b1;
          mosi_d    = 1'b0;
          rx_data_d = rx_sh_q;
        end else begin
          div_d = div_q - DIVW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state_q   <= IDLE;
      mode_q    <= '0;
      div_q     <= '0;
      edge_q    <= '0;
      tx_sh_q   <= '0;
      rx_sh_q   <= '0;
      rx_data_q <= '0;
      sclk_q    <= 1'b0;
      mosi_q    <= 1'b0;
      ss_q      <= 1'b1;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      div_q     <= div_d;
      edge_q    <= edge_d;
      tx_sh_q   <= tx_sh_d;
      rx_sh_q   <= rx_sh_d;
      rx_data_q <= rx_data_d;
      sclk_q    <= sclk_d;
      mosi_q    <= mosi_d;
      ss_q      <= ss_d;
      done_q    <= done_d;
    end
  end

  assign Busy   = (state_q != IDLE);
  assign Done   = done_q;
  assign RxData = rx_data_q;
  assign SClk   = sclk_q;
  assign MOSI   = mosi_q;
  assign SS     = ss_q;

endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master: two instances (8-bit/div 4 and 16-bit/div 2), each with a
// behavioural SPI slave. Times are Clk sample edges: a value seen after edge e counts as e+1.
module tb_spi_master;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [1:0]  mode_a, mode_b;
  logic        start_a, start_b;
  logic [7:0]  tx_a, rx_a;
  logic [15:0] tx_b, rx_b;
  logic        busy_a, done_a, sclk_a, mosi_a, ss_a, miso_a;
  logic        busy_b, done_b, sclk_b, mosi_b, ss_b, miso_b;

  spi_master u_a (
    .Clk(clk), .Rst_n(rst_n), .MODE(mode_a), .Start(start_a), .TxData(tx_a),
    .Busy(busy_a), .Done(done_a), .RxData(rx_a), .SClk(sclk_a), .MOSI(mosi_a),
    .SS(ss_a), .MISO(miso_a)
  );

  spi_master #(.DATA_WIDTH(16), .CLK_DIV(2)) u_b (
    .Clk(clk), .Rst_n(rst_n), .MODE(mode_b), .Start(start_b), .TxData(tx_b),
    .Busy(busy_b), .Done(done_b), .RxData(rx_b), .SClk(sclk_b), .MOSI(mosi_b),
    .SS(ss_b), .MISO(miso_b)
  );

  // slave models, index 0 -> u_a, index 1 -> u_b; words are kept left-aligned in 16 bits
  logic [15:0] sl_load [2];
  logic [15:0] sl_tx   [2];
  logic [15:0] sl_rx   [2];
  logic [15:0] sl_word [2];
  logic [1:0]  sl_mode [2];
  logic        sl_miso [2];
  logic        sl_psclk[2];
  logic        sl_pss  [2];
  assign miso_a = sl_miso[0];
  assign miso_b = sl_miso[1];

  int n_chk = 0;
  int n_err = 0;
  int n_done [2];
  int t_done [2];
  int ss_fall_t, ss_rise_t, busy_low_a, t0;
  logic prev_ss_a;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic slave_step(input int i, input int w, input logic [1:0] m,
                            input logic sclk, input logic ss, input logic mosi);
    logic lead;
    if (ss) begin
      if (!sl_pss[i]) sl_word[i] = sl_rx[i] & 16'((32'd1 << w) - 32'd1);
    end else if (sl_pss[i]) begin
      sl_mode[i] = m;
      sl_tx[i]   = sl_load[i] << (16 - w);
      sl_rx[i]   = '0;
      if (!m[0]) sl_miso[i] = sl_tx[i][15];
    end else if (sclk != sl_psclk[i]) begin
      lead = (sclk != sl_mode[i][1]);
      if (lead != sl_mode[i][0]) begin
        sl_rx[i] = {sl_rx[i][14:0], mosi};
      end else if (sl_mode[i][0]) begin
        sl_miso[i] = sl_tx[i][15];
        sl_tx[i]   = sl_tx[i] << 1;
      end else begin
        sl_tx[i]   = sl_tx[i] << 1;
        sl_miso[i] = sl_tx[i][15];
      end
    end
    sl_psclk[i] = sclk;
    sl_pss[i]   = ss;
  endtask

  task automatic tick();
    @(negedge clk);
    slave_step(0, 8, mode_a, sclk_a, ss_a, mosi_a);
    slave_step(1, 16, mode_b, sclk_b, ss_b, mosi_b);
    if (done_a) begin n_done[0]++; t_done[0] = cyc + 1; end
    if (done_b) begin n_done[1]++; t_done[1] = cyc + 1; end
    if (!busy_a) busy_low_a++;
    if (!ss_a && prev_ss_a) ss_fall_t = cyc + 1;
    if (ss_a && !prev_ss_a) ss_rise_t = cyc + 1;
    prev_ss_a = ss_a;
  endtask

  // raise Start for one sampling edge; t0 is the edge that sampled it
  task automatic go(input int i);
    if (i == 0) start_a = 1'b1; else start_b = 1'b1;
    tick();
    t0 = cyc;
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  task automatic wait_done(input int i, input int limit, input string tag);
    int n0;
    n0 = n_done[i];
    for (int k = 0; k < limit && n_done[i] == n0; k++) tick();
    check_eq(tag, 32'(n_done[i] != n0), 1);
  endtask

  int d1, d2, r1, n0;

  initial begin
    rst_n = 1'b0;
    mode_a = 2'b00; start_a = 1'b0; tx_a = '0;
    mode_b = 2'b00; start_b = 1'b0; tx_b = '0;
    n_done = '{0, 0}; t_done = '{0, 0};
    sl_load = '{16'h0, 16'h0}; sl_tx = '{16'h0, 16'h0}; sl_rx = '{16'h0, 16'h0};
    sl_word = '{16'h0, 16'h0}; sl_mode = '{2'b00, 2'b00}; sl_miso = '{1'b0, 1'b0};
    sl_psclk = '{1'b0, 1'b0}; sl_pss = '{1'b1, 1'b1};
    ss_fall_t = 0; ss_rise_t = 0; busy_low_a = 0; prev_ss_a = 1'b1; t0 = 0;
    repeat (3) tick();
    check_eq("rst_ss", ss_a, 1);
    check_eq("rst_sclk", sclk_a, 0);
    check_eq("rst_mosi", mosi_a, 0);
    check_eq("rst_busy", busy_a, 0);
    check_eq("rst_done", done_a, 0);
    check_eq("rst_rx", rx_a, 0);
    check_eq("rst_ss_b", ss_b, 1);
    rst_n = 1'b1;
    repeat (2) tick();

    // mode 0, 0xA5 out, 0x3C back
    mode_a = 2'b00; tx_a = 8'hA5; sl_load[0] = 16'h003C;
    go(0);
    wait_done(0, 200, "t1_done");
    check_eq("t1_rx", rx_a, 8'h3C);
    check_eq("t1_slave_rx", sl_word[0], 16'h00A5);
    check_eq("t1_done_time", t_done[0] - t0, 69);
    check_eq("t1_ss_fall", ss_fall_t - t0, 1);
    check_eq("t1_ss_rise", ss_rise_t - t0, 69);
    check_eq("t1_busy_end", busy_a, 0);
    tick();
    check_eq("t1_done_pulse", done_a, 0);

    // all four modes, 0x81 against 0x7E
    for (int m = 0; m < 4; m++) begin
      mode_a = 2'(m); tx_a = 8'h81; sl_load[0] = 16'h007E;
      repeat (2) tick();
      check_eq("mode_idle_before", sclk_a, (m >> 1) & 1);
      go(0);
      wait_done(0, 200, "mode_done");
      check_eq("mode_rx", rx_a, 8'h7E);
      check_eq("mode_slave_rx", sl_word[0], 16'h0081);
      tick();
      check_eq("mode_idle_after", sclk_a, (m >> 1) & 1);
    end

    // Start held high: three back-to-back transfers
    mode_a = 2'b00; repeat (2) tick();
    sl_load[0] = 16'h0000; tx_a = 8'h01; start_a = 1'b1;
    tick();
    t0 = cyc;
    wait_done(0, 200, "b2b_done1");
    d1 = t_done[0]; r1 = ss_rise_t;
    check_eq("b2b_word1", sl_word[0], 16'h0001);
    tx_a = 8'h02;
    wait_done(0, 200, "b2b_done2");
    d2 = t_done[0];
    check_eq("b2b_gap12", d2 - d1, 69);
    check_eq("b2b_ss_high", ss_fall_t - r1, 1);
    check_eq("b2b_word2", sl_word[0], 16'h0002);
    tx_a = 8'h03;
    wait_done(0, 200, "b2b_done3");
    start_a = 1'b0;
    check_eq("b2b_gap23", t_done[0] - d2, 69);
    check_eq("b2b_word3", sl_word[0], 16'h0003);
    n0 = n_done[0];
    repeat (80) tick();
    check_eq("b2b_no_fourth", n_done[0] - n0, 0);

    // Start, MODE and TxData changes during a transfer are ignored
    mode_a = 2'b00; tx_a = 8'h5A; sl_load[0] = 16'h00C3;
    repeat (2) tick();
    n0 = n_done[0];
    go(0);
    busy_low_a = 0;
    while (cyc < t0 + 9) tick();
    start_a = 1'b1; tx_a = 8'hFF; mode_a = 2'b11;
    tick();
    start_a = 1'b0;
    while (cyc < t0 + 39) tick();
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    while (cyc < t0 + 68) tick();
    check_eq("ign_one_done", n_done[0] - n0, 1);
    check_eq("ign_done_time", t_done[0] - t0, 69);
    check_eq("ign_busy_low_cycles", busy_low_a, 1);
    check_eq("ign_rx", rx_a, 8'hC3);
    check_eq("ign_slave_rx", sl_word[0], 16'h005A);
    mode_a = 2'b00;
    repeat (80) tick();
    check_eq("ign_no_extra", n_done[0] - n0, 1);

    // reset in the middle of a transfer, then a fresh transfer
    mode_a = 2'b10; tx_a = 8'h96; sl_load[0] = 16'h0055;
    repeat (2) tick();
    n0 = n_done[0];
    go(0);
    while (cyc < t0 + 29) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check_eq("mid_rst_ss", ss_a, 1);
    check_eq("mid_rst_sclk", sclk_a, 0);
    check_eq("mid_rst_busy", busy_a, 0);
    check_eq("mid_rst_rx", rx_a, 0);
    check_eq("mid_rst_mosi", mosi_a, 0);
    while (cyc < t0 + 39) tick();
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    wait_done(0, 200, "mid_rst_done");
    check_eq("mid_rst_one_done", n_done[0] - n0, 1);
    check_eq("mid_rst_done_time", t_done[0] - t0, 109);
    check_eq("mid_rst_rx2", rx_a, 8'h55);
    check_eq("mid_rst_slave_rx", sl_word[0], 16'h0096);

    // Start in the same cycle as reset is dropped
    rst_n = 1'b0; start_a = 1'b1;
    tick();
    rst_n = 1'b1; start_a = 1'b0;
    repeat (2) tick();
    check_eq("rst_start_busy", busy_a, 0);
    check_eq("rst_start_ss", ss_a, 1);

    // 16-bit instance, CLK_DIV 2, mode 3
    mode_b = 2'b11; tx_b = 16'hBEEF; sl_load[1] = 16'h1234;
    repeat (2) tick();
    go(1);
    wait_done(1, 200, "w16_done");
    check_eq("w16_rx", rx_b, 16'h1234);
    check_eq("w16_slave_rx", sl_word[1], 16'hBEEF);
    check_eq("w16_done_time", t_done[1] - t0, 67);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
